// File: rtl/pipe_adder_pkg.sv
// Shared constants and the slice-width helper for the pipelined adder.
// Default geometry: 16-bit operands split across 4 stages.
package pipe_adder_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// add_slice: SW-bit ripple-carry adder, a + b + cin -> {cout, s}.
// Latency: purely combinational.
// Backpressure: none, no state.
module add_slice #(
    parameter int SW = 4
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] s,
    output logic          cout
);

    always_comb begin
        logic c;
        c = cin;
        s = '0;
        for (int i = 0; i < SW; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit adder split into STAGES slices, one slice per stage; PIPE_ADDER_OVF_EN adds signed overflow.
// Latency: STAGES cycles from acceptance to out_valid, one result per cycle sustained.
// Backpressure: valid/ready per stage with bubble collapsing; holds STAGES results when out_ready is low.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int SW = slice_width(WIDTH, STAGES);

    // Stage k holds the finished low (k+1)*SW sum bits and only the operand
    // bits above its slice, so register widths shrink/grow down the pipe.
    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic [WIDTH-k*SW-1:0] a_rem;
        logic [WIDTH-k*SW-1:0] b_rem;
        logic                  c_in;
        logic                  v_in;
        logic                  adv;
        logic                  vld_q;
        logic                  cy_q;
        logic                  cy;
        logic [SW-1:0]         s;
        logic [(k+1)*SW-1:0]   sm_nxt;
        logic [(k+1)*SW-1:0]   sm_q;

        if (k == 0) begin : g_src
            assign a_rem  = a;
            assign b_rem  = b;
            assign c_in   = cin;
            assign v_in   = in_valid;
            assign sm_nxt = s;
        end else begin : g_src
            assign a_rem  = g_stg[k-1].g_op.a_q;
            assign b_rem  = g_stg[k-1].g_op.b_q;
            assign c_in   = g_stg[k-1].cy_q;
            assign v_in   = g_stg[k-1].vld_q;
            assign sm_nxt = {s, g_stg[k-1].sm_q};
        end

        if (k == STAGES - 1) begin : g_adv
            assign adv = out_ready || !vld_q;
        end else begin : g_adv
            assign adv = !vld_q || g_stg[k+1].adv;
        end

        add_slice #(.SW(SW)) u_slice (
            .a    (a_rem[SW-1:0]),
            .b    (b_rem[SW-1:0]),
            .cin  (c_in),
            .s    (s),
            .cout (cy)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                sm_q  <= '0;
            end else if (adv) begin
                vld_q <= v_in;
                if (v_in) begin
                    cy_q <= cy;
                    sm_q <= sm_nxt;
                end
            end
        end

        if (k < STAGES - 1) begin : g_op
            logic [WIDTH-(k+1)*SW-1:0] a_q;
            logic [WIDTH-(k+1)*SW-1:0] b_q;

            always_ff @(posedge clk) begin
                if (adv && v_in) begin
                    a_q <= a_rem[WIDTH-k*SW-1:SW];
                    b_q <= b_rem[WIDTH-k*SW-1:SW];
                end
            end
        end
    end

    assign in_ready  = !g_stg[0].vld_q || g_stg[0].adv;
    assign out_valid = g_stg[STAGES-1].vld_q;
    assign sum       = g_stg[STAGES-1].sm_q;
    assign cout      = g_stg[STAGES-1].cy_q;

`ifdef PIPE_ADDER_OVF_EN
    // The operand MSBs are still in flight at the last stage, so overflow is
    // resolved there alongside the top sum slice.
    logic a_msb;
    logic b_msb;
    logic s_msb;

    assign a_msb = g_stg[STAGES-1].a_rem[SW-1];
    assign b_msb = g_stg[STAGES-1].b_rem[SW-1];
    assign s_msb = g_stg[STAGES-1].s[SW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (g_stg[STAGES-1].adv && g_stg[STAGES-1].v_in) begin
            ovf <= (a_msb == b_msb) && (s_msb != a_msb);
        end
    end
`endif

endmodule
